// File: rtl/conv5x5_mac.sv
// conv5x5_mac: pipelined KXxKY convolution with serially loaded, atomically
// committed signed kernel and bias, followed by ReLU, shift and saturation.
module conv5x5_mac #(
  parameter int I_F_BW = 8,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int SHIFT  = 0,
  parameter int O_F_BW = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_in_valid,
  input  logic [KX*KY*I_F_BW-1:0]  i_window,
  input  logic                     i_w_valid,
  input  logic [B_BW-1:0]          i_w_data,
  output logic                     o_w_ready,
  output logic                     o_out_valid,
  output logic [O_F_BW-1:0]        o_out_pixel
);

  localparam int N       = KX * KY;
  localparam int PROD_BW = I_F_BW + 1 + W_BW;
  localparam int SUM_BW  = PROD_BW + $clog2(N);
  localparam int ACC_BW  = ((SUM_BW > B_BW) ? SUM_BW : B_BW) + 1;
  localparam int IDX_BW  = $clog2(N + 1);
  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << O_F_BW) - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} ld_state_t;

  ld_state_t                 state;
  logic [IDX_BW-1:0]         ld_idx;
  logic signed [W_BW-1:0]    shadow_w [N];
  logic signed [W_BW-1:0]    active_w [N];
  logic signed [B_BW-1:0]    active_b;

  logic [3:0]                vld;
  logic signed [PROD_BW-1:0] prod_s1 [N];
  logic signed [B_BW-1:0]    bias_s1;
  logic signed [ACC_BW-1:0]  row_c [KY];
  logic signed [ACC_BW-1:0]  row_s2 [KY];
  logic signed [B_BW-1:0]    bias_s2;
  logic signed [ACC_BW-1:0]  total_c;
  logic signed [ACC_BW-1:0]  total_s3;
  logic signed [ACC_BW-1:0]  shifted_c;
  logic [O_F_BW-1:0]         post_c;
  logic [O_F_BW-1:0]         pix_s4;

  // Kernel load FSM: fill shadow weights, commit weights+bias on the bias word.
  // The bias word goes straight to the active set since it commits on arrival.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      ld_idx    <= '0;
      o_w_ready <= 1'b0;
      active_b  <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        shadow_w[k] <= '0;
        active_w[k] <= '0;
      end
    end else begin
      case (state)
        EMPTY, READY: begin
          if (i_w_valid) begin
            shadow_w[ld_idx] <= i_w_data[W_BW-1:0];
            ld_idx           <= ld_idx + 1'b1;
            state            <= LOADING;
          end
        end
        LOADING: begin
          if (i_w_valid) begin
            if (ld_idx == IDX_BW'(N)) begin
              active_w  <= shadow_w;
              active_b  <= i_w_data;
              ld_idx    <= '0;
              o_w_ready <= 1'b1;
              state     <= READY;
            end else begin
              shadow_w[ld_idx] <= i_w_data[W_BW-1:0];
              ld_idx           <= ld_idx + 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stage 1: products with the current active set plus a bias snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld     <= '0;
      bias_s1 <= '0;
      for (int unsigned k = 0; k < N; k++) prod_s1[k] <= '0;
    end else begin
      vld     <= {vld[2:0], i_in_valid & o_w_ready};
      bias_s1 <= active_b;
      for (int unsigned k = 0; k < N; k++)
        prod_s1[k] <= PROD_BW'($signed({1'b0, i_window[k*I_F_BW +: I_F_BW]}))
                      * PROD_BW'(active_w[k]);
    end
  end

  // Row sums of the stage-1 products.
  always_comb begin
    for (int unsigned y = 0; y < KY; y++) begin
      row_c[y] = '0;
      for (int unsigned x = 0; x < KX; x++)
        row_c[y] = row_c[y] + ACC_BW'(prod_s1[y*KX + x]);
    end
  end

  // Total of row sums plus bias.
  always_comb begin
    total_c = ACC_BW'(bias_s2);
    for (int unsigned y = 0; y < KY; y++) total_c = total_c + row_s2[y];
  end

  // ReLU, arithmetic shift, saturate to the output range.
  always_comb begin
    shifted_c = total_s3 >>> SHIFT;
    if (total_s3[ACC_BW-1])        post_c = '0;
    else if (shifted_c > SAT_MAX)  post_c = '1;
    else                           post_c = shifted_c[O_F_BW-1:0];
  end

  // Stages 2..4 and the output register; pixel holds while no result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bias_s2     <= '0;
      total_s3    <= '0;
      pix_s4      <= '0;
      o_out_valid <= 1'b0;
      o_out_pixel <= '0;
      for (int unsigned y = 0; y < KY; y++) row_s2[y] <= '0;
    end else begin
      row_s2      <= row_c;
      bias_s2     <= bias_s1;
      total_s3    <= total_c;
      pix_s4      <= post_c;
      o_out_valid <= vld[3];
      if (vld[3]) o_out_pixel <= pix_s4;
    end
  end

endmodule

// File: tb/tb_conv5x5_mac.sv
// Self-checking bench for conv5x5_mac: SHIFT=0 and SHIFT=2 instances share
// stimulus and are checked against one behavioural model every cycle.
module tb_conv5x5_mac;

  localparam int N = 25;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [N*8-1:0]   window = '0;
  logic             w_valid = 1'b0;
  logic [15:0]      w_data = '0;
  logic             wr0, ov0, wr2, ov2;
  logic [7:0]       px0, px2;

  conv5x5_mac u_dut0 (
    .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_window(window),
    .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(wr0),
    .o_out_valid(ov0), .o_out_pixel(px0)
  );

  conv5x5_mac #(.SHIFT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_window(window),
    .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(wr2),
    .o_out_valid(ov2), .o_out_pixel(px2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit signed [7:0] m_sh [N];
  bit signed [7:0] m_w  [N];
  int              m_b = 0;
  int              m_idx = 0;
  bit              m_ready = 1'b0;
  int              cyc = 0;

  typedef struct { int due; int p0; int p2; } exp_t;
  exp_t q[$];

  function automatic int ref_px(input logic [N*8-1:0] win, input int sh);
    int s;
    s = m_b;
    for (int k = 0; k < N; k++) s += int'(win[k*8 +: 8]) * int'(m_w[k]);
    if (s < 0) return 0;
    s = s >>> sh;
    return (s > 255) ? 255 : s;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin m_sh[k] = 0; m_w[k] = 0; end
      m_b = 0; m_idx = 0; m_ready = 0;
      q.delete();
    end else begin
      cyc++;
      if (in_valid && m_ready)
        q.push_back('{due: cyc + 4, p0: ref_px(window, 0), p2: ref_px(window, 2)});
      if (w_valid) begin
        if (m_idx < N) begin
          m_sh[m_idx] = w_data[7:0];
          m_idx++;
        end else begin
          m_w = m_sh;
          m_b = int'($signed(w_data));
          m_idx = 0;
          m_ready = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int last0 = 0;
  int last2 = 0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      check("rst_valid", {ov2, ov0}, 0);
      check("rst_pixel", {px2, px0}, 0);
      check("rst_ready", {wr2, wr0}, 0);
      last0 = 0; last2 = 0;
    end else begin
      check("w_ready0", wr0, m_ready);
      check("w_ready2", wr2, m_ready);
      if (q.size() > 0 && q[0].due == cyc) begin
        check("out_valid0", ov0, 1);
        check("out_valid2", ov2, 1);
        check("out_pixel0", px0, q[0].p0);
        check("out_pixel2", px2, q[0].p2);
        last0 = q[0].p0; last2 = q[0].p2;
        void'(q.pop_front());
      end else begin
        check("idle_valid0", ov0, 0);
        check("idle_valid2", ov2, 0);
        check("hold_pixel0", px0, last0);
        check("hold_pixel2", px2, last2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*8-1:0] fill_win(input logic [7:0] v);
    logic [N*8-1:0] w;
    for (int k = 0; k < N; k++) w[k*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [N*8-1:0] rand_win();
    logic [N*8-1:0] w;
    for (int k = 0; k < N; k++) w[k*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  // mode 0: all weights wv; mode 1: only k=12 is wv; mode 2: random weights
  task automatic load_kernel(input int mode, input int wv, input int bias, input bit stream);
    for (int i = 0; i <= N; i++) begin
      w_valid  = 1'b1;
      in_valid = stream;
      if (i < N)
        w_data = (mode == 2) ? 16'($urandom) : ((mode == 1 && i != 12) ? 16'd0 : 16'(wv));
      else
        w_data = 16'(bias);
      step();
    end
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic one_window(input logic [N*8-1:0] win, input int e0, input int e2, input string name);
    window = win;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({name, "_early"}, ov0, 0);
      step();
    end
    check({name, "_early"}, ov0, 0);
    step();
    check({name, "_valid"}, {ov2, ov0}, 2'b11);
    check({name, "_px0"}, px0, e0);
    check({name, "_px2"}, px2, e2);
    step();
    check({name, "_drop"}, ov0, 0);
    check({name, "_hold"}, px0, e0);
  endtask

  initial begin
    logic [N*8-1:0] w;
    #1 reset_n = 1'b0;
    #1;
    check("reset_outputs", {ov0, px0, wr0}, 0);
    repeat (3) step();
    reset_n = 1'b1;

    // Windows before and during the first load are dropped.
    window = fill_win(8'd3);
    in_valid = 1'b1;
    step();
    check("pre_load_ready", wr0, 0);
    load_kernel(0, 1, 0, 1'b1);
    in_valid = 1'b0;
    check("first_commit_ready", wr0, 1);
    repeat (6) step();

    one_window(fill_win(8'd2), 50, 12, "ones_x2");
    one_window(fill_win(8'd255), 255, 255, "sat");
    load_kernel(0, -1, 0, 1'b0);
    one_window(fill_win(8'd255), 0, 0, "relu");
    load_kernel(1, 1, 0, 1'b0);
    w = rand_win();
    w[12*8 +: 8] = 8'd77;
    one_window(w, 77, 19, "center");
    load_kernel(0, 1, 3, 1'b0);
    one_window(fill_win(8'd1), 28, 7, "bias3");

    // Reload 1s/bias 0 -> 2s/bias 4 while streaming windows of 1s.
    load_kernel(0, 1, 0, 1'b0);
    window = fill_win(8'd1);
    in_valid = 1'b1;
    load_kernel(0, 2, 4, 1'b1);
    repeat (3) step();
    check("reload_old_px0", px0, 25);
    step();
    check("reload_commit_px0", px0, 25);
    check("reload_commit_px2", px2, 6);
    step();
    check("reload_new_px0", px0, 54);
    check("reload_new_px2", px2, 13);
    in_valid = 1'b0;
    repeat (6) step();

    // Reset mid-stream and mid-load.
    window = rand_win();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      w_data = 16'($urandom);
      step();
    end
    w_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", {ov2, ov0}, 0);
    check("midreset_pixel", {px2, px0}, 0);
    check("midreset_ready", {wr2, wr0}, 0);
    step();
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("post_reset_drop", ov0, 0);
    load_kernel(2, 0, int'($urandom_range(0, 65535)), 1'b1);

    // Random traffic with interleaved, gappy kernel reloads.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      window   = (($urandom % 3) == 0) ? fill_win(8'($urandom % 8)) : rand_win();
      w_valid  = ($urandom % 3) == 0;
      w_data   = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    w_valid  = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
